// File: rtl/demux_event_arbiter.sv
// demux_event_arbiter: captures pulses on the demux's one-hot output lines into
// a pending register and serializes them, round-robin, as line indices over a
// valid/ready handshake. Sticky overflow flags any event that could not be held.
module demux_event_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned IDXW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    y_in,
  input  logic            clr_all,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic [N-1:0]    pending,
  output logic            overflow
);

  localparam int unsigned SUMW = IDXW + 1;

  logic [N-1:0]    pending_q, pending_d;
  logic            out_valid_q, out_valid_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            overflow_q, overflow_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic            slot_free_c;
  logic            gnt_found_c;
  logic [IDXW-1:0] gnt_idx_c;
  logic [N-1:0]    grant_c;

  // Index ptr+off, wrapped modulo N (off < N).
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned off);
    logic [SUMW-1:0] s;
    s = {1'b0, base} + SUMW'(off);
    if (s >= SUMW'(N)) s = s - SUMW'(N);
    return s[IDXW-1:0];
  endfunction

  // Round-robin search over the registered pending bits, starting at ptr.
  always_comb begin
    slot_free_c = !out_valid_q || out_ready;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    grant_c     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_found_c && pending_q[wrap_add(ptr_q, i)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = wrap_add(ptr_q, i);
      end
    end
    if (slot_free_c && gnt_found_c) grant_c[gnt_idx_c] = 1'b1;
  end

  // Next-state: pending capture, output slot load/hold, overflow detection.
  always_comb begin
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    overflow_d  = overflow_q;
    ptr_d       = ptr_q;
    if (clr_all) begin
      pending_d   = '0;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      // A bit granted this cycle may be re-set by a same-cycle arrival.
      pending_d  = (pending_q & ~grant_c) | y_in;
      overflow_d = overflow_q | (|(y_in & pending_q & ~grant_c));
      if (slot_free_c) begin
        if (gnt_found_c) begin
          out_valid_d = 1'b1;
          out_idx_d   = gnt_idx_c;
          ptr_d       = (gnt_idx_c == IDXW'(N - 1)) ? '0 : gnt_idx_c + 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      overflow_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      overflow_q  <= overflow_d;
      ptr_q       <= ptr_d;
    end
  end

  assign pending   = pending_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_demux_event_arbiter.sv
// Testbench for demux_event_arbiter: directed scenarios plus a randomized run,
// all checked against an event-level reference model.
module tb_demux_event_arbiter;

  localparam int unsigned N    = 32;
  localparam int unsigned IDXW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    y_in;
  logic            clr_all;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic [N-1:0]    pending;
  logic            overflow;

  demux_event_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .clr_all   (clr_all),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: set of waiting events, the output slot, the pointer.
  logic [N-1:0] m_pend;
  logic         m_valid;
  int           m_idx;
  int           m_ptr;
  logic         m_ovf;

  // Event accounting for the randomized run.
  int n_inj, n_xfer, n_lost;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] y, input logic rdy, input logic clr);
    rst_n = r; y_in = y; out_ready = rdy; clr_all = clr;
  endtask

  // One clock: advance the model by the event rules, then compare all outputs.
  task automatic tick();
    logic obs_xfer;
    logic slot;
    int   g, k;
    obs_xfer = out_valid && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_pend = '0; m_valid = 1'b0; m_idx = 0; m_ovf = 1'b0; m_ptr = 0;
    end else if (clr_all) begin
      m_pend = '0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      if (obs_xfer) n_xfer++;
      slot = !m_valid || out_ready;
      g = -1;
      if (slot) begin
        for (int off = 0; off < int'(N); off++) begin
          k = (m_ptr + off) % int'(N);
          if (g < 0 && m_pend[k]) g = k;
        end
      end
      for (int b = 0; b < int'(N); b++) begin
        if (y_in[b]) begin
          n_inj++;
          if (m_pend[b] && b != g) begin
            n_lost++;
            m_ovf = 1'b1;
          end
        end
      end
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend = m_pend | y_in;
      if (slot) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_idx   = g;
          m_ptr   = (g + 1) % int'(N);
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
    chk("model_pending", pending, m_pend);
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_idx", 32'(out_idx), 32'(m_idx));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_ovf = 1'b0;
    n_inj = 0; n_xfer = 0; n_lost = 0;

    // Reset held two cycles with all lines active.
    drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick(); tick();
    chk("rst_pending", pending, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_pending", pending, 32'h0);

    // Single event on line 10.
    drive(1'b1, 32'h0000_0400, 1'b1, 1'b0); tick();
    chk("single_pending", pending, 32'h400);
    chk("single_valid_early", 32'(out_valid), 32'h0);
    drive(1'b1, 32'h0, 1'b1, 1'b0); tick();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_idx", 32'(out_idx), 32'd10);
    tick();
    chk("single_drop", 32'(out_valid), 32'h0);

    // Round-robin with wrap, starting from pointer 0.
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h8000_0003, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    tick(); chk("rr_idx0", 32'(out_idx), 32'd0);
    tick(); chk("rr_idx1", 32'(out_idx), 32'd1);
    tick(); chk("rr_idx31", 32'(out_idx), 32'd31);
    tick(); chk("rr_idle", 32'(out_valid), 32'h0);
    drive(1'b1, 32'h1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h0, 1'b1, 1'b0); tick();
    chk("rr_wrap_valid", 32'(out_valid), 32'h1);
    chk("rr_wrap_idx", 32'(out_idx), 32'd0);
    tick();

    // Back-pressure and overflow.
    drive(1'b1, 32'h20, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0); tick();
    chk("bp_idx5", 32'(out_idx), 32'd5);
    drive(1'b1, 32'h80, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h80, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0, 1'b0, 1'b0); tick();
    chk("bp_idx_hold", 32'(out_idx), 32'd5);
    chk("bp_valid_hold", 32'(out_valid), 32'h1);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_pending", pending, 32'h80);
    drive(1'b1, 32'h0, 1'b1, 1'b0); tick();
    chk("bp_idx7", 32'(out_idx), 32'd7);
    chk("bp_pending_empty", pending, 32'h0);
    tick();
    chk("bp_once", 32'(out_valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    drive(1'b1, 32'h0, 1'b1, 1'b1); tick();
    chk("clr_ovf", 32'(overflow), 32'h0);

    // Same-cycle grant and re-arrival on line 3.
    drive(1'b1, 32'h8, 1'b1, 1'b0); tick();
    tick();
    chk("re_idx", 32'(out_idx), 32'd3);
    chk("re_pending", pending, 32'h8);
    chk("re_ovf", 32'(overflow), 32'h0);
    drive(1'b1, 32'h0, 1'b1, 1'b0); tick();
    chk("re_second_valid", 32'(out_valid), 32'h1);
    chk("re_second_idx", 32'(out_idx), 32'd3);
    tick();
    chk("re_done", 32'(out_valid), 32'h0);

    // Fairness: all lines at once from pointer 0.
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < int'(N); i++) begin
      tick();
      chk("fair_valid", 32'(out_valid), 32'h1);
      chk("fair_idx", 32'(out_idx), 32'(i));
    end
    tick();
    chk("fair_end", 32'(out_valid), 32'h0);
    chk("fair_ovf", 32'(overflow), 32'h0);

    // Randomized traffic with random back-pressure.
    n_inj = 0; n_xfer = 0; n_lost = 0;
    for (int c = 0; c < 1000; c++) begin
      logic [N-1:0] y;
      y = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'h0;
      drive(1'b1, y, ($urandom_range(0, 3) != 0), 1'b0);
      tick();
    end
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    chk("scoreboard", 32'(n_inj),
        32'(n_xfer + $countones(pending) + int'(out_valid) + n_lost));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
